// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader.
//   - state_e           : dump FSM states
//   - DefaultAddrW/DataW: default register index / data widths
package regfile_dump_pkg;

    localparam int unsigned DefaultAddrW = 5;
    localparam int unsigned DefaultDataW = 32;

    // StCsum is only reachable when REGFILE_DUMP_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
        StCsum,
        StDone
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_out_reg.sv
// dump_out_reg: output holding register for the dump stream.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : capture index/data/last and mark the beat valid
//   flush_i        : drop the pending beat (abort); wins over load
//   ready_i        : downstream ready; a handshake retires the beat
//   index_i/data_i/last_i : payload to capture on load
//   valid_o/index_o/data_o/last_o : registered beat; payload holds while stalled
module dump_out_reg
    import regfile_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] index_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] index_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] index_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            // Load beats a same-cycle handshake so a back-to-back beat stays valid.
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i && !flush_i) begin
                index_q <= index_i;
                data_q  <= data_i;
                last_q  <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign index_o = index_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range (wrapping modulo 2**ADDR_W), reads
// each register through the shared read port and streams it over valid/ready.
// Optional macro REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   start_i, first_reg_i, last_reg_i : start a dump over [first, last]
//   abort_i                   : cancel the dump, no done pulse
//   busy_o, done_o            : dump in progress / one-cycle completion pulse
//   rf_read_reg_o, rf_read_data_i : register file read port
//   out_valid_o, out_ready_i, out_index_o, out_data_o, out_last_o : beat stream
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DATA_W = DefaultDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_reg_i,
    input  logic [ADDR_W-1:0] last_reg_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rf_read_reg_o,
    input  logic [DATA_W-1:0] rf_read_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_index_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic              load;
    logic              flush;
    logic [ADDR_W-1:0] load_index;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              handshake;
    logic              at_last;

    assign handshake = out_valid_o && out_ready_i;
    assign at_last   = (cur_q == last_q);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        load       = 1'b0;
        flush      = 1'b0;
        load_index = cur_q;
        load_data  = rf_read_data_i;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
        load_last  = 1'b0;  // the checksum beat is always the final one
`else
        load_last  = at_last;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cur_d   = first_reg_i;
                    last_d  = last_reg_i;
                    state_d = StRead;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StRead: begin
                load    = 1'b1;  // snapshot the register into the holding register
                state_d = StSend;
            end
            StSend: begin
                if (handshake) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ out_data_o;
`endif
                    if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Queue the checksum beat directly behind the last register beat.
                        load       = 1'b1;
                        load_index = '0;
                        load_data  = csum_q ^ out_data_o;
                        load_last  = 1'b1;
                        state_d    = StCsum;
`else
                        state_d    = StDone;
`endif
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            StCsum: begin
                if (handshake) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            flush   = 1'b1;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cur_q   <= '0;
            last_q  <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    dump_out_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (out_ready_i),
        .index_i (load_index),
        .data_i  (load_data),
        .last_i  (load_last),
        .valid_o (out_valid_o),
        .index_o (out_index_o),
        .data_o  (out_data_o),
        .last_o  (out_last_o)
    );

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign rf_read_reg_o = cur_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a behavioural register file and a
// queue-based model of the expected beat sequence for each dump.
module tb_regfile_dump_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  first_reg_i = '0;
    logic [4:0]  last_reg_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  rf_read_reg_o;
    logic [31:0] rf_read_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  out_index_o;
    logic [31:0] out_data_o;
    logic        out_last_o;

    logic [31:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    assign rf_read_data_i = rf[rf_read_reg_o];

    always #5 clk_i = ~clk_i;

    regfile_dump_reader #(
        .ADDR_W(5),
        .DATA_W(32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .first_reg_i    (first_reg_i),
        .last_reg_i     (last_reg_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rf_read_reg_o  (rf_read_reg_o),
        .rf_read_data_i (rf_read_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_index_o    (out_index_o),
        .out_data_o     (out_data_o),
        .out_last_o     (out_last_o)
    );

    // Runs one dump over [f, l]. mode 0: ready always 1; 1: random ready;
    // 2: ready held low for 5 cycles while the second beat is offered.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                           input bit check_lat, input string name);
        logic [4:0]  ei[$];
        logic [31:0] ed[$];
        bit          el[$];
        logic [4:0]  idx;
        logic [31:0] x;
        int got = 0;
        int last_hs = -1;
        int done_cyc = -1;
        int first_v = -1;
        int stall = 0;
        bit pv = 0, pr = 0, pl = 0;
        logic [4:0]  pi = '0;
        logic [31:0] pd = '0;

        // Expected sequence: indices f, f+1, ... (mod 32) up to and including l.
        idx = f;
        x = '0;
        forever begin
            ei.push_back(idx);
            ed.push_back(rf[idx]);
            el.push_back(1'b0);
            x = x ^ rf[idx];
            if (idx == l) break;
            idx = idx + 5'd1;
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        ei.push_back(5'd0);
        ed.push_back(x);
        el.push_back(1'b1);
`else
        el[el.size()-1] = 1'b1;
`endif

        @(negedge clk_i);
        first_reg_i = f;
        last_reg_i  = l;
        start_i     = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        first_reg_i = $urandom;  // latched values must not follow the inputs
        last_reg_i  = $urandom;
        if (check_lat) begin
            n_cmp++;
            if (busy_o !== 1'b1) begin
                $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
                n_err++;
            end
        end
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (mode == 0) out_ready_i = 1'b1;
            else if (mode == 1) out_ready_i = ($urandom_range(0, 3) != 0);
            else if (got == 1 && out_valid_o && stall < 5) begin
                out_ready_i = 1'b0;
                stall++;
            end else out_ready_i = 1'b1;

            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (pv && !pr) begin
                n_cmp++;
                if ({out_valid_o, out_index_o, out_data_o, out_last_o} !== {1'b1, pi, pd, pl}) begin
                    $display("FAIL %s stall_hold: got v=%b i=%0d d=%h l=%b want v=1 i=%0d d=%h l=%b",
                             name, out_valid_o, out_index_o, out_data_o, out_last_o, pi, pd, pl);
                    n_err++;
                end
            end
            if (out_valid_o) begin
                if (first_v < 0) first_v = cyc;
                if (out_ready_i) begin
                    n_cmp++;
                    if (got >= ei.size()) begin
                        $display("FAIL %s extra_beat: got index %0d want no beat", name, out_index_o);
                        n_err++;
                    end else if ({out_index_o, out_data_o, out_last_o} !== {ei[got], ed[got], el[got]}) begin
                        $display("FAIL %s beat%0d: got i=%0d d=%h l=%b want i=%0d d=%h l=%b", name, got,
                                 out_index_o, out_data_o, out_last_o, ei[got], ed[got], el[got]);
                        n_err++;
                    end
                    got++;
                    last_hs = cyc;
                end else if (out_index_o != 5'd0) begin
                    // Overwrite the register behind a pending beat; the beat must not change.
                    rf[out_index_o] = ~rf[out_index_o];
                end
            end
            pv = out_valid_o; pr = out_ready_i;
            pi = out_index_o; pd = out_data_o; pl = out_last_o;
            @(negedge clk_i);
        end

        n_cmp++;
        if (got != ei.size()) begin
            $display("FAIL %s beat_count: got %0d want %0d", name, got, ei.size());
            n_err++;
        end
        n_cmp++;
        if (done_cyc < 0 || done_cyc != last_hs + 1) begin
            $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_hs + 1);
            n_err++;
        end
        if (check_lat) begin
            n_cmp++;
            if (first_v != 2) begin
                $display("FAIL %s first_valid_latency: got %0d want 2", name, first_v);
                n_err++;
            end
        end
        @(negedge clk_i);
        n_cmp++;
        if ({done_o, busy_o, out_valid_o} !== 3'b000) begin
            $display("FAIL %s after_done: got done/busy/valid=%b want 000", name,
                     {done_o, busy_o, out_valid_o});
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({busy_o, done_o, out_valid_o, out_last_o, out_index_o, out_data_o, rf_read_reg_o} !== '0) begin
            $display("FAIL reset_values: got busy=%b done=%b v=%b l=%b i=%0d d=%h rr=%0d want all 0",
                     busy_o, done_o, out_valid_o, out_last_o, out_index_o, out_data_o, rf_read_reg_o);
            n_err++;
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        first_reg_i = 5'd3; last_reg_i = 5'd20; start_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, out_valid_o, out_last_o, out_index_o, out_data_o, rf_read_reg_o} !== '0) begin
            $display("FAIL async_reset: got busy=%b v=%b i=%0d d=%h rr=%0d want all 0",
                     busy_o, out_valid_o, out_index_o, out_data_o, rf_read_reg_o);
            n_err++;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        do_dump(5'd1, 5'd3, 0, 1'b1, "basic");
    endtask

    task automatic test_backpressure();
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        do_dump(5'd1, 5'd3, 2, 1'b0, "backpressure");
    endtask

    task automatic test_wrap();
        do_dump(5'd30, 5'd1, 0, 1'b0, "wrap");
    endtask

    task automatic test_single();
        do_dump(5'd5, 5'd5, 0, 1'b1, "single");
    endtask

    task automatic test_abort();
        int hs = 0;
        bit seen = 0;
        @(negedge clk_i);
        first_reg_i = 5'd0; last_reg_i = 5'd7; start_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 40 && hs < 2; c++) begin
            if (out_valid_o && out_ready_i) hs++;
            @(negedge clk_i);
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        n_cmp++;
        if (hs != 2 || {out_valid_o, busy_o, done_o} !== 3'b000) begin
            $display("FAIL abort_after_two: got hs=%0d v/busy/done=%b want hs=2 000", hs,
                     {out_valid_o, busy_o, done_o});
            n_err++;
        end
        repeat (3) begin
            if (done_o) seen = 1;
            @(negedge clk_i);
        end
        n_cmp++;
        if (seen) begin
            $display("FAIL abort_no_done: got done pulse want none");
            n_err++;
        end
        // Abort while a beat is stalled: valid drops without a handshake.
        first_reg_i = 5'd10; last_reg_i = 5'd12; start_i = 1'b1; out_ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        n_cmp++;
        if ({out_valid_o, busy_o} !== 2'b00) begin
            $display("FAIL abort_stalled: got v/busy=%b want 00", {out_valid_o, busy_o});
            n_err++;
        end
        do_dump(5'd4, 5'd4, 0, 1'b1, "restart");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            do_dump(5'($urandom), 5'($urandom), 1, 1'b0, "random");
        end
    endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        rf[1] = 32'hF0F00000; rf[2] = 32'h0F0F00FF;
        do_dump(5'd1, 5'd2, 0, 1'b0, "checksum");
    endtask
`endif

    initial begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_single();
        test_abort();
        test_async_reset();
        test_random();
`ifdef REGFILE_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug/trace reader for the 32-entry register file: on a start pulse it walks a programmable register range, drives the register file's read port, and streams each register's contents out over a valid/ready interface. It sits beside the core's register file. It shares a read port with the decode path through a debug mux that is outside this block, and it feeds the debug/trace output channel.

## Interface
- `ADDR_W`, 5: register index width; walks modulo 2**ADDR_W.
- `DATA_W`, 32: register data width.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `first_reg`  in  ADDR_W  first index of range; latched with `start`.
- `last_reg`  in  ADDR_W  last index of range; latched with `start`.
- `abort`  in  1  cancel the dump in progress.
- `busy`  out  1  high from the cycle after `start` is accepted until return to IDLE.
- `done`  out  1  one-cycle pulse when a dump completes normally.
- `rf_read_reg`  out  ADDR_W  read address to the register file.
- `rf_read_data`  in  DATA_W  combinational read data from the register file.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_index`  out  ADDR_W  register index of the current beat.
- `out_data`  out  DATA_W  register contents of the current beat.
- `out_last`  out  1  final beat of the dump.

## Operation
- FSM states:
  - IDLE: `start`=1 latches `first_reg`/`last_reg`, sets `cur`=`first_reg`, and moves to READ.
  - READ: drives `rf_read_reg`=`cur` and captures `rf_read_data` into `out_data`. It sets `out_index`=`cur` and sets `out_last`=(`cur`==`last`), with the checksum rule below. Moves to SEND.
  - SEND: `out_valid`=1. On `out_valid`&`out_ready`:
    - if `cur`==`last`, go to CSUM when the checksum is enabled, otherwise to DONE;
    - otherwise set `cur`=`cur`+1 (mod 2**ADDR_W) and go to READ.
  - CSUM: only exists with the macro; see Configuration.
  - DONE: `done`=1 for one cycle, then IDLE.
- Range:
  - `first_reg`==`last_reg` gives exactly one beat.
  - `first_reg`>`last_reg` wraps through 2**ADDR_W-1 to 0, e.g. 30,31,0,1.
  - A range is never empty.
- Data is a snapshot taken in the READ cycle. Later register-file writes to that index do not alter a pending beat.
- `start` while busy is ignored. `start` during DONE is ignored; it is accepted on the next IDLE cycle.
- `abort`, in any non-IDLE state, returns the FSM to IDLE next cycle with no `done` pulse. `out_valid` drops even without a handshake; this is the only case where valid falls before ready.
- `rf_read_reg` holds `cur` in all states.

## Timing
- Reset values: all outputs 0. That covers `busy`, `done`, `out_valid`, `out_last`, `out_index`, `out_data`, and `rf_read_reg`. FSM resets to IDLE.
- Assertion of `reset` clears state immediately, asynchronously, mid-dump included. The first `start` is accepted on the first rising edge after deassertion.
- Start accepted at edge N: READ in cycle N+1, first `out_valid` in cycle N+2.
- Minimum 2 cycles per beat (READ+SEND); with `out_ready` held 1, beats appear every 2 cycles.
- While `out_valid`=1 and `out_ready`=0, `out_index`, `out_data`, and `out_last` are held stable.
- `done` asserts the cycle after the final handshake, or after the CSUM handshake when the checksum is enabled.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN`:
  - Defined: a running XOR of every `out_data` value sent is kept, cleared on `start`. After the last register beat, CSUM sends one extra beat: `out_data` = the XOR, `out_index`=0, `out_last`=1. Register beats never assert `out_last`.
  - Undefined: no accumulator and no CSUM state; `out_last` marks the beat of `last_reg`.

## Structure
- Package `regfile_dump_pkg`: FSM state enum (IDLE, READ, SEND, CSUM, DONE) and default `ADDR_W`/`DATA_W` localparams.
- One sub-module: `dump_out_reg`, the output holding register (valid/index/data/last with load and hold-on-stall).

## Test plan
- Basic range: x1=0x11, x2=0x22, x3=0x33; range 1..3; `out_ready`=1.
  - Expect beats (1,0x11), (2,0x22), (3,0x33) with `out_last` on the third.
  - First `out_valid` 2 cycles after `start`; `done` pulses 1 cycle after the third handshake.
- Backpressure: `out_ready`=0 for 5 cycles during the second beat. Expect index 2 / data 0x22 held stable, `cur` not advancing, and no beat lost or duplicated.
- Wrap: range 30..1. Expect indices 30, 31, 0, 1; index 0 data = 0.
- Single register: range 5..5. Expect exactly one beat, index 5, `out_last`=1, then `done`.
- Abort then restart: `abort` after the second handshake of range 0..7.
  - Next cycle: `out_valid`=0, `busy`=0, and no `done` pulse.
  - A new `start` with range 4..4 yields a single beat at index 4.
- Checksum (macro defined): x1=0xF0F00000, x2=0x0F0F00FF; range 1..2. Expect beats 0xF0F00000 and 0x0F0F00FF, both with `out_last`=0. Then a CSUM beat with index 0, data 0xFFFF00FF, `out_last`=1.
